// File: rtl/demux2_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | demux2_buf: steers a valid/ready stream into two independent FIFOs   |
// | (sel=1 -> port A, sel=0 -> port B), each drained by its own handshake|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module demux2_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_sel,
  output logic                   a_valid,
  input  logic                   a_ready,
  output logic [WIDTH-1:0]       a_data,
  output logic                   b_valid,
  input  logic                   b_ready,
  output logic [WIDTH-1:0]       b_data,
  output logic [$clog2(DEPTH):0] a_count,
  output logic [$clog2(DEPTH):0] b_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] c_full = CW'(DEPTH);
  localparam logic [CW-1:0] c_cone = CW'(1);
  localparam logic [PW-1:0] c_pone = PW'(1);

  // Index 0 is port A, index 1 is port B.
  logic [1:0]            w_cons_ready;
  logic [1:0][CW-1:0]    w_cnt;
  logic [1:0][WIDTH-1:0] w_head;

  assign w_cons_ready = {b_ready, a_ready};

  // Depends only on in_sel and registered counts: no consumer-ready path.
  assign in_ready = in_sel ? (w_cnt[0] != c_full) : (w_cnt[1] != c_full);

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    localparam logic c_sel = (gi == 0);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wp;
    logic [PW-1:0]    r_rp;
    logic [CW-1:0]    r_cnt;
    logic             w_push;
    logic             w_pop;

    assign w_push     = in_valid && in_ready && (in_sel == c_sel);
    assign w_pop      = (r_cnt != '0) && w_cons_ready[gi];
    assign w_cnt[gi]  = r_cnt;
    assign w_head[gi] = r_mem[r_rp];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k < DEPTH; k++) begin
          r_mem[k] <= '0;
        end
        r_wp  <= '0;
        r_rp  <= '0;
        r_cnt <= '0;
      end else begin
        if (w_push) begin
          r_mem[r_wp] <= in_data;
          r_wp        <= r_wp + c_pone;
        end
        if (w_pop) begin
          r_rp <= r_rp + c_pone;
        end
        case ({w_push, w_pop})
          2'b10:   r_cnt <= r_cnt + c_cone;
          2'b01:   r_cnt <= r_cnt - c_cone;
          default: r_cnt <= r_cnt;
        endcase
      end
    end
  end : g_port

  assign a_valid = (w_cnt[0] != '0);
  assign b_valid = (w_cnt[1] != '0);
  assign a_data  = w_head[0];
  assign b_data  = w_head[1];
  assign a_count = w_cnt[0];
  assign b_count = w_cnt[1];

endmodule
`default_nettype wire

// File: tb/tb_demux2_buf.sv
`default_nettype none
// Self-checking bench for demux2_buf: queue-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_demux2_buf;
  localparam int WIDTH = 32;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, in_sel;
  logic [WIDTH-1:0] in_data;
  logic             a_valid, a_ready, b_valid, b_ready;
  logic [WIDTH-1:0] a_data, b_data;
  logic [$clog2(DEPTH):0] a_count, b_count;

  int tests = 0;
  int fails = 0;

  demux2_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
    .a_count(a_count), .b_count(b_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one queue per port, updated from the inputs seen at each edge.
  logic [WIDTH-1:0] qa[$];
  logic [WIDTH-1:0] qb[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      qa.delete();
      qb.delete();
    end else begin
      bit acc, pa, pb;
      acc = in_valid && (in_sel ? (qa.size() != DEPTH) : (qb.size() != DEPTH));
      pa  = (qa.size() != 0) && a_ready;
      pb  = (qb.size() != 0) && b_ready;
      if (pa) void'(qa.pop_front());
      if (pb) void'(qb.pop_front());
      if (acc) begin
        if (in_sel) qa.push_back(in_data);
        else        qb.push_back(in_data);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_in_ready", 64'(in_ready),
          64'(in_sel ? (qa.size() != DEPTH) : (qb.size() != DEPTH)));
      chk("m_a_valid", 64'(a_valid), 64'(qa.size() != 0));
      chk("m_b_valid", 64'(b_valid), 64'(qb.size() != 0));
      chk("m_a_count", 64'(a_count), 64'(qa.size()));
      chk("m_b_count", 64'(b_count), 64'(qb.size()));
      if (qa.size() != 0) chk("m_a_data", 64'(a_data), 64'(qa[0]));
      if (qb.size() != 0) chk("m_b_data", 64'(b_data), 64'(qb[0]));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [WIDTH-1:0] d);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b1, '0);
    a_ready = 1'b0;
    b_ready = 1'b0;
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_a_valid",  64'(a_valid),  64'd0);
    chk("rst_b_valid",  64'(b_valid),  64'd0);
    chk("rst_a_data",   64'(a_data),   64'd0);
    chk("rst_b_data",   64'(b_data),   64'd0);
    chk("rst_counts",   64'({a_count, b_count}), 64'd0);
    tick();
    rst = 1'b0;

    // Back-to-back routing to A then B with both consumers ready.
    a_ready = 1'b1;
    b_ready = 1'b1;
    drive(1'b1, 1'b1, 32'h11111111);
    tick();
    chk("t1_a_valid", 64'(a_valid), 64'd1);
    chk("t1_a_data",  64'(a_data),  64'h11111111);
    drive(1'b1, 1'b0, 32'h22222222);
    tick();
    chk("t1_b_valid", 64'(b_valid), 64'd1);
    chk("t1_b_data",  64'(b_data),  64'h22222222);
    chk("t1_a_count", 64'(a_count), 64'd0);
    drive(1'b0, 1'b0, '0);
    tick();
    chk("t1_counts0", 64'({a_count, b_count}), 64'd0);

    // Stalled A does not block B.
    a_ready = 1'b0;
    b_ready = 1'b0;
    drive(1'b1, 1'b1, 32'hA0);
    tick();
    drive(1'b1, 1'b1, 32'hA1);
    tick();
    drive(1'b1, 1'b1, 32'hA2);
    #1;
    chk("t2_a_count_full", 64'(a_count),  64'd2);
    chk("t2_in_ready_a",   64'(in_ready), 64'd0);
    drive(1'b1, 1'b0, 32'hB0);
    #1;
    chk("t2_in_ready_b",   64'(in_ready), 64'd1);
    tick();
    chk("t2_b_data",  64'(b_data),  64'hB0);
    chk("t2_b_valid", 64'(b_valid), 64'd1);
    drive(1'b0, 1'b0, '0);
    a_ready = 1'b1;
    b_ready = 1'b1;
    #1;
    chk("t2_a_head0", 64'(a_data), 64'hA0);
    tick();
    chk("t2_a_head1", 64'(a_data), 64'hA1);
    tick();
    chk("t2_a_empty", 64'(a_valid), 64'd0);

    // Full port refuses a push even while popping the same cycle.
    a_ready = 1'b0;
    drive(1'b1, 1'b1, 32'hD0);
    tick();
    drive(1'b1, 1'b1, 32'hD1);
    tick();
    drive(1'b1, 1'b1, 32'hD2);
    a_ready = 1'b1;
    #1;
    chk("t3_full_ready", 64'(in_ready), 64'd0);
    tick();
    chk("t3_a_count", 64'(a_count), 64'd1);
    chk("t3_a_data",  64'(a_data),  64'hD1);
    chk("t3_ready_back", 64'(in_ready), 64'd1);
    a_ready = 1'b0;
    tick();
    chk("t3_a_count2", 64'(a_count), 64'd2);
    drive(1'b0, 1'b1, '0);
    a_ready = 1'b1;
    tick();
    chk("t3_drain_d2", 64'(a_data), 64'hD2);
    tick();
    chk("t3_drained", 64'(a_count), 64'd0);

    // Count stays at 1 through simultaneous push/pop; pointers wrap.
    a_ready = 1'b0;
    drive(1'b1, 1'b1, 32'hC0);
    tick();
    chk("t4_seed", 64'(a_count), 64'd1);
    a_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      drive(1'b1, 1'b1, 32'hC0 + 32'(k));
      tick();
      chk("t4_count", 64'(a_count), 64'd1);
      chk("t4_data",  64'(a_data),  64'hC0 + 64'(k));
    end
    drive(1'b0, 1'b1, '0);
    tick();
    chk("t4_empty", 64'(a_count), 64'd0);

    // Asynchronous reset mid-cycle discards buffered B word.
    b_ready = 1'b0;
    drive(1'b1, 1'b0, 32'hB7);
    tick();
    chk("t5_b_count", 64'(b_count), 64'd1);
    chk("t5_b_data",  64'(b_data),  64'hB7);
    drive(1'b0, 1'b0, '0);
    #1;
    rst = 1'b1;
    #1;
    chk("t5_rst_b_valid", 64'(b_valid), 64'd0);
    chk("t5_rst_b_count", 64'(b_count), 64'd0);
    chk("t5_rst_b_data",  64'(b_data),  64'd0);
    tick();
    rst = 1'b0;
    b_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      tests++;
      if (b_data === 32'hB7) begin
        fails++;
        $display("FAIL t5_no_b7: got %0h expected not b7", b_data);
      end
    end
    drive(1'b1, 1'b0, 32'h33);
    tick();
    chk("t5_post_b_data", 64'(b_data), 64'h33);
    drive(1'b0, 1'b0, '0);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/demux2_buf.md
# demux2_buf

Two-way routing demultiplexer with per-port buffering: the write-side counterpart of the 2:1 select mux in the conditional-move/Hamming datapath. A single valid/ready input stream carries a data word and a select bit. Each word is steered into one of two independent FIFO buffers, port A or port B. Each output port drains through its own valid/ready handshake, so a stalled consumer on one port never blocks traffic destined for the other once that word is buffered.

## Interface
Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 2, entries per output FIFO; power of two, ≥ 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  word will be accepted this cycle.
- in_data  input  WIDTH  word to route.
- in_sel  input  1  1 → port A, 0 → port B. Same polarity as the datapath mux: sel=1 selects a.
- a_valid  output  1  port A head word available.
- a_ready  input  1  port A consumer takes head word.
- a_data  output  WIDTH  port A head word.
- b_valid  output  1  port B head word available.
- b_ready  input  1  port B consumer takes head word.
- b_data  output  WIDTH  port B head word.
- a_count  output  $clog2(DEPTH)+1  port A occupancy.
- b_count  output  $clog2(DEPTH)+1  port B occupancy.

## Operation
- Each port is a circular FIFO with storage array, write pointer, read pointer ($clog2(DEPTH) bits each, wrap modulo DEPTH) and occupancy counter (0..DEPTH).
- in_ready = in_sel ? (a_count != DEPTH) : (b_count != DEPTH). This is combinational on in_sel and the registered counts only. It never depends on a_ready or b_ready, so there are no comb paths from consumer ready to producer ready.
- Push: in_valid && in_ready. Writes in_data at the selected port's write pointer, advances that pointer, and increments its count (unless popped same cycle). The unselected port is untouched.
- Pop on port X: X_valid && X_ready. Advances the read pointer and decrements count (unless pushed same cycle).
- Simultaneous push and pop on the same port: the count is unchanged and both pointers advance. This is legal only when count ≠ DEPTH. A full port refuses the push even if it pops that same cycle, so there is no pass-through when full.
- Push into one port while the other pops: the operations are fully independent.
- X_valid = (X_count != 0). X_data = storage[read pointer]. This is registered storage, with no bypass from in_data.
- Per-port ordering is strictly FIFO. There is no ordering guarantee between ports.
- The producer may change in_sel or in_data while in_valid is low. While in_valid is high and in_ready is low, the producer must hold in_data and in_sel stable; the block does not check this.
- Reset (async assert, any time, including mid-transfer):
  - All pointers and counts are cleared to 0.
  - a_valid and b_valid go to 0 and all storage is cleared to 0, so a_data and b_data read 0.
  - Buffered words are discarded.
- Deassertion takes effect at the next rising edge, with no synchronizer inside the block.

## Timing
- Latency: a word accepted at edge k shows X_valid=1 with that word on X_data in the cycle after edge k. The minimum is 1 cycle.
- Throughput: 1 word/cycle total into the block. Each port sustains 1 word/cycle out when its consumer holds ready high.
- Occupancy: DEPTH words per port, with no extra skid entry.
- Count outputs update on the same edge as the push/pop that changes them.
- Reset values:
  - in_ready = 1, since both counts are 0.
  - a_valid = b_valid = 0.
  - a_data = b_data = 0.
  - a_count = b_count = 0.

## Test plan
- Reset, then route 0x11111111 (sel=1) and 0x22222222 (sel=0) in back-to-back cycles with both readies high. Expect:
  - a_valid one cycle after the first accept, with a_data=0x11111111.
  - b_valid one cycle after the second accept, with b_data=0x22222222.
  - Both counts return to 0.
- Hold a_ready=0 and push 0xA0,0xA1 to A. Expect a_count=2 and in_ready=0 while in_sel=1. Switch to sel=0 and push 0xB0: it is accepted, and b_data=0xB0. Then release a_ready: port A emits 0xA0 then 0xA1, in order.
- Port A full (DEPTH=2), a_ready=1, in_valid=1, sel=1 on the same cycle. Expect in_ready=0, the pop occurs, a_count=1, and the push is accepted on the next cycle.
- Port A count=1 with simultaneous push 0xC1 and pop. Expect a_count to stay 1, a_data to become 0xC1, and the pointers to wrap correctly over 6 consecutive cycles with the sequence 0xC1..0xC6 intact.
- Port B at count=1 holding 0xB7: assert rst asynchronously mid-cycle. Expect b_valid=0, b_count=0 and b_data=0 immediately, before the next edge. After release, 0xB7 never appears on b_data.
